ahb_chfifo_slave: RTL

//  AHB-lite slave that front-ends NUM_CH independent FIFOs packed into one external dual-port RAM.
//  Bus masters push words and read or flush per-channel status over AHB.

---
 rtl/ahb_chfifo_pkg.sv | 36 +++
 rtl/chfifo_ptr.sv | 50 +++++
 rtl/ahb_chfifo_slave.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_chfifo_pkg.sv
// Shared bus encodings, register map and status layout for the multi-channel AHB FIFO slave.
package ahb_chfifo_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_e;

  localparam logic [1:0] REG_PUSH   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_FLUSH  = 2'd2;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 24;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chfifo_ptr.sv
// Per-channel FIFO bookkeeping: read/write pointers, occupancy and the sticky overflow flag.
module chfifo_ptr #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic do_push;
  logic do_pop;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // Full is taken from the registered count, so a same-cycle pop never rescues a push.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ahb_chfifo_slave.sv
// AHB-lite slave fronting NUM_CH FIFOs packed into one external dual-port RAM,
// with a fixed-priority shared pop port for downstream consumers.
module ahb_chfifo_slave
  import ahb_chfifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NUM_CH = 2,
  localparam int CW    = ch_width(NUM_CH)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  output logic              HREADY,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA,
  output logic [CW+AW-1:0]  mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic [CW+AW-1:0]  mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [NUM_CH-1:0] rd_req,
  output logic              rd_valid,
  output logic [CW-1:0]     rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] fifo_empty,
  output logic [NUM_CH-1:0] fifo_full
);

  err_state_e state, state_n;
  hresp_e     hresp_c;
  logic       hready_c;

  logic [NUM_CH-1:0][AW-1:0] wptr_v;
  logic [NUM_CH-1:0][AW-1:0] rptr_v;
  logic [NUM_CH-1:0][AW:0]   cnt_v;
  logic [NUM_CH-1:0]         ovf_v;

  logic          dp_vld_p1, wr_p1;
  logic [1:0]    reg_p1;
  logic [CW-1:0] ch_p1;

  logic          accept, dec_err;
  logic [CW-1:0] a_ch;
  logic          dp_act, dp_push, dp_flush, push_full;
  logic          gnt_vld_p0, pop_fire;
  logic [CW-1:0] gnt_ch_p0;
  logic          unused_inputs;

  function automatic logic [31:0] status_word(input logic [AW:0] cnt, input logic emp,
                                              input logic fl, input logic ov);
    logic [31:0] w;
    w                 = '0;
    w[AW:0]           = cnt;
    w[STAT_EMPTY_BIT] = emp;
    w[STAT_FULL_BIT]  = fl;
    w[STAT_OVF_BIT]   = ov;
    return w;
  endfunction

  assign unused_inputs = ^{HBURST, HADDR, HTRANS[0], HWDATA};

  // Address phase: decode and register the beat
  assign a_ch    = HADDR[4 +: CW];
  assign dec_err = ({1'b0, HADDR[7:4]} >= 5'(NUM_CH)) | (HSIZE != HSIZE_WORD) |
                   (HADDR[1:0] != 2'b00);
  assign accept  = HSEL & HTRANS[1] & hready_c;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_vld_p1 <= 1'b0;
      wr_p1     <= 1'b0;
      reg_p1    <= '0;
      ch_p1     <= '0;
      HRDATA    <= '0;
    end else if (hready_c) begin
      dp_vld_p1 <= accept & ~dec_err;
      wr_p1     <= HWRITE;
      reg_p1    <= HADDR[3:2];
      ch_p1     <= a_ch;
      HRDATA    <= (accept && !dec_err && !HWRITE && HADDR[3:2] == REG_STATUS) ?
                   status_word(cnt_v[a_ch], fifo_empty[a_ch], fifo_full[a_ch], ovf_v[a_ch]) : '0;
    end
  end

  // Data phase: act on the registered beat; error cycles never touch FIFO state
  assign dp_act    = dp_vld_p1 & (state == ST_IDLE);
  assign dp_push   = dp_act & wr_p1 & (reg_p1 == REG_PUSH);
  assign dp_flush  = dp_act & wr_p1 & (reg_p1 == REG_FLUSH);
  assign push_full = dp_push & fifo_full[ch_p1];

  assign mem_write = dp_push & ~fifo_full[ch_p1];
  assign mem_waddr = {ch_p1, wptr_v[ch_p1]};
  assign mem_wdata = HWDATA[DATA_W-1:0];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_n;
  end

  // A push into a full channel is only known in its data phase, so it skips straight to ERR2.
  always_comb begin
    state_n  = state;
    hready_c = 1'b1;
    hresp_c  = HRESP_OKAY;
    unique case (state)
      ST_IDLE: begin
        if (push_full) begin
          hready_c = 1'b0;
          hresp_c  = HRESP_ERROR;
          state_n  = ST_ERR2;
        end else if (HSEL && HTRANS[1] && dec_err) begin
          state_n = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = HRESP_ERROR;
        state_n  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_c = HRESP_ERROR;
        state_n = (HSEL && HTRANS[1] && dec_err) ? ST_ERR1 : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign HREADY = hready_c;
  assign HRESP  = hresp_c;

  // Pop grant stage: lowest non-empty requesting channel wins
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_ch_p0  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rd_req[i] && !fifo_empty[i]) begin
        gnt_vld_p0 = 1'b1;
        gnt_ch_p0  = CW'(i);
      end
    end
  end

  assign pop_fire  = gnt_vld_p0 & ~(dp_flush & (ch_p1 == gnt_ch_p0));
  assign mem_raddr = {gnt_ch_p0, rptr_v[gnt_ch_p0]};

  // Pop data stage: RAM output lands one cycle after the grant
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_valid <= 1'b0;
      rd_ch    <= '0;
    end else begin
      rd_valid <= pop_fire;
      if (pop_fire) rd_ch <= gnt_ch_p0;
    end
  end

  assign rd_data = mem_rdata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    chfifo_ptr #(.AW(AW)) u_ptr (
      .clk      (HCLK),
      .rst      (HRESET),
      .push     (dp_push & (ch_p1 == CW'(i))),
      .pop      (pop_fire & (gnt_ch_p0 == CW'(i))),
      .flush    (dp_flush & (ch_p1 == CW'(i))),
      .wptr     (wptr_v[i]),
      .rptr     (rptr_v[i]),
      .count    (cnt_v[i]),
      .empty    (fifo_empty[i]),
      .full     (fifo_full[i]),
      .overflow (ovf_v[i])
    );
  end

endmodule
